// File: rtl/mm_job_sched_if.sv
// Command, controller and completion signals of the matrix-multiply job scheduler.
// The slave modport is the scheduler; the master modport is its surrounding host/controller.
interface mm_job_sched_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 4,
   parameter int ID_W       = 4
);
   localparam int PW = $clog2(DEPTH + 1);

   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [ADDR_WIDTH-1:0] cmd_base_addra_i;
   logic [ADDR_WIDTH-1:0] cmd_base_addrb_i;
   logic [ADDR_WIDTH-1:0] cmd_base_addrp_i;
   logic [3:0]            cmd_k_i;
   logic [3:0]            cmd_m_i;
   logic [3:0]            cmd_n_i;
   logic [ID_W-1:0]       cmd_id_i;

   logic                  start_o;
   logic [ADDR_WIDTH-1:0] base_addra_o;
   logic [ADDR_WIDTH-1:0] base_addrb_o;
   logic [ADDR_WIDTH-1:0] base_addrp_o;
   logic [3:0]            k_o;
   logic [3:0]            m_o;
   logic [3:0]            n_o;
   logic                  done_i;

   logic                  cpl_valid_o;
   logic                  cpl_ready_i;
   logic [ID_W-1:0]       cpl_id_o;
   logic [1:0]            cpl_err_o;

   logic                  busy_o;
   logic [PW-1:0]         pending_o;
   logic                  spurious_o;

   modport slave (
      input  cmd_valid_i, cmd_base_addra_i, cmd_base_addrb_i, cmd_base_addrp_i,
             cmd_k_i, cmd_m_i, cmd_n_i, cmd_id_i, done_i, cpl_ready_i,
      output cmd_ready_o, start_o, base_addra_o, base_addrb_o, base_addrp_o,
             k_o, m_o, n_o, cpl_valid_o, cpl_id_o, cpl_err_o, busy_o, pending_o, spurious_o
   );

   modport master (
      output cmd_valid_i, cmd_base_addra_i, cmd_base_addrb_i, cmd_base_addrp_i,
             cmd_k_i, cmd_m_i, cmd_n_i, cmd_id_i, done_i, cpl_ready_i,
      input  cmd_ready_o, start_o, base_addra_o, base_addrb_o, base_addrp_o,
             k_o, m_o, n_o, cpl_valid_o, cpl_id_o, cpl_err_o, busy_o, pending_o, spurious_o
   );
endinterface

// File: rtl/mm_job_sched.sv
// Job scheduler in front of the matrix-multiply controller: queues jobs in a small FIFO,
// launches them one at a time with a start pulse and returns one completion record per job.
module mm_job_sched #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 4,
   parameter int ID_W       = 4,
   parameter int TIMEOUT    = 1024
) (
   input logic           clk_i,
   input logic           rst_i,
   mm_job_sched_if.slave sif
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] a;
      logic [ADDR_WIDTH-1:0] b;
      logic [ADDR_WIDTH-1:0] p;
      logic [3:0]            k;
      logic [3:0]            m;
      logic [3:0]            n;
      logic [ID_W-1:0]       id;
   } job_t;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_CPL} state_t;

   job_t            fifo_mem [DEPTH];
   job_t            cmd_job;
   job_t            head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [PW-1:0]   count;
   logic            push;
   logic            pop;
   logic            head_zero;
   state_t          state;
   logic [TW-1:0]   timer;
   logic [ID_W-1:0] cur_id;

   assign cmd_job = '{a: sif.cmd_base_addra_i, b: sif.cmd_base_addrb_i, p: sif.cmd_base_addrp_i,
                      k: sif.cmd_k_i, m: sif.cmd_m_i, n: sif.cmd_n_i, id: sif.cmd_id_i};

   assign sif.cmd_ready_o = (count < FULL);
   assign sif.pending_o   = count;
   assign push            = sif.cmd_valid_i && sif.cmd_ready_o;
   // Pop only reads entries written on an earlier edge, so there is no same-cycle bypass.
   assign pop             = (state == S_IDLE) && (count != '0);
   assign head            = fifo_mem[rd_ptr];
   assign head_zero       = (head.k == 4'd0) || (head.m == 4'd0) || (head.n == 4'd0);

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= cmd_job;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state            <= S_IDLE;
         timer            <= '0;
         cur_id           <= '0;
         sif.start_o      <= 1'b0;
         sif.cpl_valid_o  <= 1'b0;
         sif.cpl_id_o     <= '0;
         sif.cpl_err_o    <= 2'b00;
         sif.busy_o       <= 1'b0;
         sif.spurious_o   <= 1'b0;
         sif.base_addra_o <= '0;
         sif.base_addrb_o <= '0;
         sif.base_addrp_o <= '0;
         sif.k_o          <= '0;
         sif.m_o          <= '0;
         sif.n_o          <= '0;
      end else begin
         sif.start_o <= 1'b0;
         if (sif.done_i && (state != S_RUN)) sif.spurious_o <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  sif.base_addra_o <= head.a;
                  sif.base_addrb_o <= head.b;
                  sif.base_addrp_o <= head.p;
                  sif.k_o          <= head.k;
                  sif.m_o          <= head.m;
                  sif.n_o          <= head.n;
                  cur_id           <= head.id;
                  sif.busy_o       <= 1'b1;
                  // A degenerate job is reported straight away and never reaches the controller.
                  if (head_zero) begin
                     state           <= S_CPL;
                     sif.cpl_valid_o <= 1'b1;
                     sif.cpl_id_o    <= head.id;
                     sif.cpl_err_o   <= 2'b01;
                  end else begin
                     state <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               sif.start_o <= 1'b1;
               timer       <= '0;
               state       <= S_RUN;
            end
            S_RUN: begin
               if (sif.done_i) begin
                  state           <= S_CPL;
                  sif.cpl_valid_o <= 1'b1;
                  sif.cpl_id_o    <= cur_id;
                  sif.cpl_err_o   <= 2'b00;
               end else if (timer == TMAX) begin
                  state           <= S_CPL;
                  sif.cpl_valid_o <= 1'b1;
                  sif.cpl_id_o    <= cur_id;
                  sif.cpl_err_o   <= 2'b10;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_CPL: begin
               if (sif.cpl_ready_i) begin
                  state           <= S_IDLE;
                  sif.cpl_valid_o <= 1'b0;
                  sif.busy_o      <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
